inst_fetcher: RTL and testbench
===============================

// Module: inst_fetcher
// PURPOSE
//  Consumes the PC stream (pc2fetch_pc/pc2fetch_enable) and returns one 32-bit
//  instruction per accepted PC to the instruction queue. Holds a direct-mapped
//  I-cache; misses go to the memory controller as whole-word reads. A ROB clear
//  (branch mispredict) squashes any in-flight fetch. Sits between PC and the IQ.
// PARAMETERS
//  ICACHE_IDX_W  6   log2 of I-cache entries (one 32-bit word per entry)
//  ADDR_W        32  address / PC width
// PORTS
//  clk_in            in   1       clock, all state on posedge
//  rst_in            in   1       synchronous active-high reset
//  rdy_in            in   1       0 = freeze all state, outputs hold
//  pc2fetch_pc       in   ADDR_W  PC to fetch
//  pc2fetch_enable   in   1       PC valid this cycle
//  fetch2pc_ready    out  1       fetcher accepts a PC this cycle
//  rob2fetch_clear   in   1       flush: drop current fetch / output
//  fetch2mem_req     out  1       word read request, held until done
//  fetch2mem_addr    out  ADDR_W  word-aligned read address
//  mem2fetch_done    in   1       one-cycle pulse, mem2fetch_data valid
//  mem2fetch_data    in   32      instruction word read from memory
//  fetch2iq_valid    out  1       instruction output valid
//  fetch2iq_inst     out  32      instruction word
//  fetch2iq_pc       out  ADDR_W  PC of fetch2iq_inst
//  iq2fetch_full     in   1       IQ cannot accept this cycle
// BEHAVIOUR
//  Reset: state IDLE; all cache valid bits 0; fetch2mem_req=0, fetch2mem_addr=0,
//   fetch2iq_valid=0, fetch2iq_inst=0, fetch2iq_pc=0. Reset mid-MISS drops req.
//  Cache: index=pc[ICACHE_IDX_W+1:2], tag=pc[ADDR_W-1:ICACHE_IDX_W+2]; pc[1:0]
//   ignored. Written only on mem2fetch_done (fill on every miss, replace in place).
//  fetch2pc_ready = (state==IDLE) && !rob2fetch_clear (combinational).
//  Accept = fetch2pc_ready && pc2fetch_enable && rdy_in; latch pc.
//  States:
//   IDLE : on accept, hit -> EMIT (inst from cache, valid at T+1);
//          miss -> MISS, fetch2mem_req=1, addr={pc[ADDR_W-1:2],2'b0} from T+1.
//   MISS : req/addr held; on done -> fill cache, EMIT with inst=data, req=0
//          (valid at D+1). On clear -> DRAIN (req stays high).
//   DRAIN: req held until done; done fills cache, no output -> IDLE. ready=0.
//   EMIT : fetch2iq_valid=1, inst/pc stable. Transfer in cycle with
//          !iq2fetch_full -> IDLE, valid=0 next cycle. Clear -> IDLE, valid=0.
//  rob2fetch_clear has priority over accept, done-to-EMIT and transfer; clear in
//   IDLE is a no-op; cache contents never invalidated by clear.
//  Clear and done in same MISS cycle: fill cache, -> IDLE, no output.
//  Max throughput: hit = 1 instruction / 2 cycles (accept, emit).
//  rdy_in=0: no state, cache or output change; done pulses are not presented by
//   mem ctrl while rdy_in=0.
// TESTING
//  1 reset; pc=0x0 enable -> req=1 addr=0x0 next cycle; done+data 0x00000513
//    after 3 cycles -> valid next cycle, inst=0x00000513, pc=0x0, req=0.
//  2 re-fetch pc=0x0 -> no req, valid exactly 1 cycle after accept, same inst.
//  3 EMIT with iq2fetch_full=1 for 4 cycles -> valid/inst/pc stable, ready=0;
//    full=0 -> transfer, ready=1 the following cycle.
//  4 clear 1 cycle into MISS for pc=0x40 -> req held to done, valid never set;
//    later fetch 0x40 hits (no req).
//  5 fetch 0x0 then 0x100 (same index, IDX_W=6) -> 0x100 misses, replaces;
//    fetch 0x0 again misses with req addr 0x0.
//  6 rdy_in=0 for 3 cycles in EMIT and in MISS -> all outputs frozen; resumes.

Source files
------------

// File: rtl/inst_fetcher_if.sv
// Bundle between the instruction fetcher and its neighbours: the PC stream,
// the ROB flush, the memory controller read port and the instruction queue.
interface inst_fetcher_if #(
   parameter int ADDR_W = 32
);
   // Handshakes:
   //  - A PC is taken in a cycle where pc2fetch_enable && fetch2pc_ready (and the core is not frozen).
   //  - An instruction is handed over in a cycle where fetch2iq_valid && !iq2fetch_full.
   //  - fetch2mem_req stays high until the one-cycle mem2fetch_done pulse arrives.
   logic [ADDR_W-1:0] pc2fetch_pc;
   logic              pc2fetch_enable;
   logic              fetch2pc_ready;
   logic              rob2fetch_clear;
   logic              fetch2mem_req;
   logic [ADDR_W-1:0] fetch2mem_addr;
   logic              mem2fetch_done;
   logic [31:0]       mem2fetch_data;
   logic              fetch2iq_valid;
   logic [31:0]       fetch2iq_inst;
   logic [ADDR_W-1:0] fetch2iq_pc;
   logic              iq2fetch_full;

   modport master (
      input  pc2fetch_pc, pc2fetch_enable, rob2fetch_clear,
      input  mem2fetch_done, mem2fetch_data, iq2fetch_full,
      output fetch2pc_ready, fetch2mem_req, fetch2mem_addr,
      output fetch2iq_valid, fetch2iq_inst, fetch2iq_pc
   );

   modport slave (
      output pc2fetch_pc, pc2fetch_enable, rob2fetch_clear,
      output mem2fetch_done, mem2fetch_data, iq2fetch_full,
      input  fetch2pc_ready, fetch2mem_req, fetch2mem_addr,
      input  fetch2iq_valid, fetch2iq_inst, fetch2iq_pc
   );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetcher: one instruction per accepted PC, served from a
// direct-mapped one-word-per-line I-cache with whole-word refills on a miss.
module inst_fetcher #(
   parameter int ICACHE_IDX_W = 6,
   parameter int ADDR_W       = 32
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                rdy_in,
   inst_fetcher_if.master      bus,
   output logic [1:0]          dbg_state
);

   localparam int ENTRIES = 1 << ICACHE_IDX_W;
   localparam int TAG_W   = ADDR_W - ICACHE_IDX_W - 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MISS  = 2'd1,
      S_DRAIN = 2'd2,
      S_EMIT  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              valid_q, valid_d;
   logic [31:0]       inst_q, inst_d;
   logic [ADDR_W-1:0] pc_q, pc_d;

   logic [ENTRIES-1:0] cache_vld_q, cache_vld_d;
   logic [TAG_W-1:0]   cache_tag_q  [ENTRIES];
   logic [31:0]        cache_data_q [ENTRIES];

   logic [ICACHE_IDX_W-1:0] lookup_idx, fill_idx;
   logic [TAG_W-1:0]        lookup_tag, fill_tag;
   logic                    hit;
   logic                    ready;
   logic                    accept;
   logic                    fill_we;
   logic                    clear;
   logic                    done;

   assign clear = bus.rob2fetch_clear;
   assign done  = bus.mem2fetch_done;

   assign lookup_idx = bus.pc2fetch_pc[ICACHE_IDX_W+1:2];
   assign lookup_tag = bus.pc2fetch_pc[ADDR_W-1:ICACHE_IDX_W+2];
   assign hit        = cache_vld_q[lookup_idx] && (cache_tag_q[lookup_idx] == lookup_tag);

   // Refills are indexed by the PC latched at accept, which is held through MISS/DRAIN.
   assign fill_idx = pc_q[ICACHE_IDX_W+1:2];
   assign fill_tag = pc_q[ADDR_W-1:ICACHE_IDX_W+2];

   assign ready   = (state_q == S_IDLE) && !clear;
   assign accept  = ready && bus.pc2fetch_enable && rdy_in;
   assign fill_we = rdy_in && done && ((state_q == S_MISS) || (state_q == S_DRAIN));

   // State register
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (rdy_in) begin
         case (state_q)
            S_IDLE: begin
               if (accept) state_d = hit ? S_EMIT : S_MISS;
            end
            S_MISS: begin
               if (done)       state_d = clear ? S_IDLE : S_EMIT;
               else if (clear) state_d = S_DRAIN;
            end
            S_DRAIN: begin
               if (done) state_d = S_IDLE;
            end
            S_EMIT: begin
               if (clear || !bus.iq2fetch_full) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output / datapath next values
   always_comb begin
      req_d       = req_q;
      addr_d      = addr_q;
      valid_d     = valid_q;
      inst_d      = inst_q;
      pc_d        = pc_q;
      cache_vld_d = cache_vld_q;
      if (fill_we) cache_vld_d[fill_idx] = 1'b1;
      if (rdy_in) begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  pc_d = bus.pc2fetch_pc;
                  if (hit) begin
                     inst_d  = cache_data_q[lookup_idx];
                     valid_d = 1'b1;
                  end else begin
                     req_d  = 1'b1;
                     addr_d = {bus.pc2fetch_pc[ADDR_W-1:2], 2'b00};
                  end
               end
            end
            S_MISS: begin
               if (done) begin
                  req_d = 1'b0;
                  if (!clear) begin
                     valid_d = 1'b1;
                     inst_d  = bus.mem2fetch_data;
                  end
               end
            end
            S_DRAIN: begin
               if (done) req_d = 1'b0;
            end
            S_EMIT: begin
               if (clear || !bus.iq2fetch_full) valid_d = 1'b0;
            end
            default: begin
               req_d   = 1'b0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         req_q       <= 1'b0;
         addr_q      <= '0;
         valid_q     <= 1'b0;
         inst_q      <= '0;
         pc_q        <= '0;
         cache_vld_q <= '0;
      end else begin
         req_q       <= req_d;
         addr_q      <= addr_d;
         valid_q     <= valid_d;
         inst_q      <= inst_d;
         pc_q        <= pc_d;
         cache_vld_q <= cache_vld_d;
      end
   end

   // Tag/data arrays need no reset; the valid bits gate every lookup.
   always_ff @(posedge clk_in) begin
      if (fill_we) begin
         cache_tag_q[fill_idx]  <= fill_tag;
         cache_data_q[fill_idx] <= bus.mem2fetch_data;
      end
   end

   assign bus.fetch2pc_ready = ready;
   assign bus.fetch2mem_req  = req_q;
   assign bus.fetch2mem_addr = addr_q;
   assign bus.fetch2iq_valid = valid_q;
   assign bus.fetch2iq_inst  = inst_q;
   assign bus.fetch2iq_pc    = pc_q;
   assign dbg_state          = state_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: a per-cycle vector table plus hand-written
// sequences for the rdy_in freeze and a reset in the middle of a miss.
module tb_inst_fetcher;

   logic clk_in;
   logic rst_in;
   logic rdy_in;
   logic [1:0] dbg_state;

   inst_fetcher_if #(.ADDR_W(32)) bus ();

   inst_fetcher #(.ICACHE_IDX_W(6), .ADDR_W(32)) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .bus       (bus.master),
      .dbg_state (dbg_state)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   typedef struct {
      logic        rdy;
      logic        en;
      logic [31:0] pc;
      logic        clr;
      logic        done;
      logic [31:0] data;
      logic        full;
      logic        e_ready;
      logic        e_valid;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      logic        e_req;
      logic [31:0] e_addr;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];

   localparam logic [31:0] I0 = 32'h0000_0513;
   localparam logic [31:0] I1 = 32'h0010_0093;
   localparam logic [31:0] I2 = 32'h0020_0113;
   localparam logic [31:0] I3 = 32'h0030_0193;
   localparam logic [31:0] I4 = 32'h0040_0213;

   function automatic vec_t mk(logic rdy, logic en, logic [31:0] pc, logic clr, logic done,
                               logic [31:0] data, logic full, logic er, logic ev,
                               logic [31:0] ei, logic [31:0] ep, logic eq, logic [31:0] ea);
      vec_t v;
      v.rdy = rdy; v.en = en; v.pc = pc; v.clr = clr; v.done = done; v.data = data;
      v.full = full; v.e_ready = er; v.e_valid = ev; v.e_inst = ei; v.e_pc = ep;
      v.e_req = eq; v.e_addr = ea;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rdy_in              = v.rdy;
      bus.pc2fetch_enable = v.en;
      bus.pc2fetch_pc     = v.pc;
      bus.rob2fetch_clear = v.clr;
      bus.mem2fetch_done  = v.done;
      bus.mem2fetch_data  = v.data;
      bus.iq2fetch_full   = v.full;
   endtask

   // Called at posedge+1: drive, check the combinational ready, then check registered outputs.
   task automatic step(input vec_t v, input string nm);
      drive(v);
      #2;
      chk({nm, " ready"}, {31'd0, bus.fetch2pc_ready}, {31'd0, v.e_ready});
      @(posedge clk_in);
      #1;
      chk({nm, " valid"}, {31'd0, bus.fetch2iq_valid}, {31'd0, v.e_valid});
      if (v.e_valid) begin
         chk({nm, " inst"}, bus.fetch2iq_inst, v.e_inst);
         chk({nm, " pc"}, bus.fetch2iq_pc, v.e_pc);
      end
      chk({nm, " req"}, {31'd0, bus.fetch2mem_req}, {31'd0, v.e_req});
      if (v.e_req) chk({nm, " addr"}, bus.fetch2mem_addr, v.e_addr);
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, " rst valid"}, {31'd0, bus.fetch2iq_valid}, 32'd0);
      chk({nm, " rst inst"}, bus.fetch2iq_inst, 32'd0);
      chk({nm, " rst pc"}, bus.fetch2iq_pc, 32'd0);
      chk({nm, " rst req"}, {31'd0, bus.fetch2mem_req}, 32'd0);
      chk({nm, " rst addr"}, bus.fetch2mem_addr, 32'd0);
      chk({nm, " rst state"}, {30'd0, dbg_state}, 32'd0);
   endtask

   initial begin
      vec_t idle;
      rst_in = 1'b1;
      idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(idle);
      repeat (2) @(posedge clk_in);
      #1;
      chk_reset("init");
      rst_in = 1'b0;
      chk("init ready", {31'd0, bus.fetch2pc_ready}, 32'd1);

      //           rdy en pc         clr dn data full | rdy vld inst pc        req addr
      // cold miss on 0x0, done after 3 wait cycles
      tbl.push_back(mk(1, 1, 32'h000, 0, 0, 0,  0,   1,  0,  0,  0,         1, 32'h000));
      tbl.push_back(mk(1, 0, 32'h000, 0, 0, 0,  0,   0,  0,  0,  0,         1, 32'h000));
      tbl.push_back(mk(1, 0, 32'h000, 0, 0, 0,  0,   0,  0,  0,  0,         1, 32'h000));
      tbl.push_back(mk(1, 0, 32'h000, 0, 0, 0,  0,   0,  0,  0,  0,         1, 32'h000));
      tbl.push_back(mk(1, 0, 32'h000, 0, 1, I0, 0,   0,  1,  I0, 32'h000,   0, 0));
      tbl.push_back(mk(1, 0, 32'h000, 0, 0, 0,  0,   0,  0,  0,  0,         0, 0));
      // hit on 0x0, then IQ full for 4 cycles
      tbl.push_back(mk(1, 1, 32'h000, 0, 0, 0,  0,   1,  1,  I0, 32'h000,   0, 0));
      tbl.push_back(mk(1, 0, 32'h000, 0, 0, 0,  1,   0,  1,  I0, 32'h000,   0, 0));
      tbl.push_back(mk(1, 0, 32'h000, 0, 0, 0,  1,   0,  1,  I0, 32'h000,   0, 0));
      tbl.push_back(mk(1, 0, 32'h000, 0, 0, 0,  1,   0,  1,  I0, 32'h000,   0, 0));
      tbl.push_back(mk(1, 0, 32'h000, 0, 0, 0,  1,   0,  1,  I0, 32'h000,   0, 0));
      tbl.push_back(mk(1, 0, 32'h000, 0, 0, 0,  0,   0,  0,  0,  0,         0, 0));
      tbl.push_back(mk(1, 0, 32'h000, 0, 0, 0,  0,   1,  0,  0,  0,         0, 0));
      // clear one cycle into a miss on 0x40: drain, then 0x40 hits
      tbl.push_back(mk(1, 1, 32'h040, 0, 0, 0,  0,   1,  0,  0,  0,         1, 32'h040));
      tbl.push_back(mk(1, 0, 32'h040, 1, 0, 0,  0,   0,  0,  0,  0,         1, 32'h040));
      tbl.push_back(mk(1, 0, 32'h040, 0, 0, 0,  0,   0,  0,  0,  0,         1, 32'h040));
      tbl.push_back(mk(1, 0, 32'h040, 0, 1, I1, 0,   0,  0,  0,  0,         0, 0));
      tbl.push_back(mk(1, 0, 32'h040, 0, 0, 0,  0,   1,  0,  0,  0,         0, 0));
      tbl.push_back(mk(1, 1, 32'h040, 0, 0, 0,  0,   1,  1,  I1, 32'h040,   0, 0));
      tbl.push_back(mk(1, 0, 32'h040, 0, 0, 0,  0,   0,  0,  0,  0,         0, 0));
      // 0x0 hits, 0x100 aliases and replaces, 0x0 then misses again
      tbl.push_back(mk(1, 1, 32'h000, 0, 0, 0,  0,   1,  1,  I0, 32'h000,   0, 0));
      tbl.push_back(mk(1, 0, 32'h000, 0, 0, 0,  0,   0,  0,  0,  0,         0, 0));
      tbl.push_back(mk(1, 1, 32'h100, 0, 0, 0,  0,   1,  0,  0,  0,         1, 32'h100));
      tbl.push_back(mk(1, 0, 32'h100, 0, 1, I2, 0,   0,  1,  I2, 32'h100,   0, 0));
      tbl.push_back(mk(1, 0, 32'h100, 0, 0, 0,  0,   0,  0,  0,  0,         0, 0));
      tbl.push_back(mk(1, 1, 32'h000, 0, 0, 0,  0,   1,  0,  0,  0,         1, 32'h000));
      tbl.push_back(mk(1, 0, 32'h000, 0, 1, I0, 0,   0,  1,  I0, 32'h000,   0, 0));
      tbl.push_back(mk(1, 0, 32'h000, 0, 0, 0,  0,   0,  0,  0,  0,         0, 0));
      // clear in IDLE blocks the accept and is otherwise a no-op
      tbl.push_back(mk(1, 1, 32'h000, 1, 0, 0,  0,   0,  0,  0,  0,         0, 0));
      tbl.push_back(mk(1, 0, 32'h000, 0, 0, 0,  0,   1,  0,  0,  0,         0, 0));
      // unaligned pc 0x206: clear and done together fill but emit nothing; later hit
      tbl.push_back(mk(1, 1, 32'h206, 0, 0, 0,  0,   1,  0,  0,  0,         1, 32'h204));
      tbl.push_back(mk(1, 0, 32'h206, 1, 1, I3, 0,   0,  0,  0,  0,         0, 0));
      tbl.push_back(mk(1, 0, 32'h000, 0, 0, 0,  0,   1,  0,  0,  0,         0, 0));
      tbl.push_back(mk(1, 1, 32'h204, 0, 0, 0,  0,   1,  1,  I3, 32'h204,   0, 0));
      // clear in EMIT drops the output even with IQ full
      tbl.push_back(mk(1, 0, 32'h000, 1, 0, 0,  1,   0,  0,  0,  0,         0, 0));
      tbl.push_back(mk(1, 0, 32'h000, 0, 0, 0,  0,   1,  0,  0,  0,         0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i], $sformatf("vec%0d", i));
      end

      // rdy_in low for 3 cycles in EMIT: nothing moves, even with IQ free
      step(mk(1, 1, 32'h040, 0, 0, 0, 0, 1, 1, I1, 32'h040, 0, 0), "frz_emit_acc");
      for (int i = 0; i < 3; i++) begin
         step(mk(0, 1, 32'h300, 0, 0, 0, 0, 0, 1, I1, 32'h040, 0, 0), $sformatf("frz_emit%0d", i));
         chk($sformatf("frz_emit%0d state", i), {30'd0, dbg_state}, 32'd3);
      end
      step(mk(1, 0, 32'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "frz_emit_xfer");

      // rdy_in low for 3 cycles in MISS: req/addr held, then the fill completes
      step(mk(1, 1, 32'h300, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h300), "frz_miss_acc");
      for (int i = 0; i < 3; i++) begin
         step(mk(0, 0, 32'h000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300), $sformatf("frz_miss%0d", i));
         chk($sformatf("frz_miss%0d state", i), {30'd0, dbg_state}, 32'd1);
      end
      step(mk(1, 0, 32'h000, 0, 1, I4, 0, 0, 1, I4, 32'h300, 0, 0), "frz_miss_done");
      step(mk(1, 0, 32'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "frz_miss_xfer");

      // reset while a miss is outstanding drops req and empties the cache
      step(mk(1, 1, 32'h380, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h380), "rst_miss_acc");
      drive(idle);
      rst_in = 1'b1;
      @(posedge clk_in);
      #1;
      chk_reset("midmiss");
      rst_in = 1'b0;
      step(mk(1, 1, 32'h000, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h000), "post_rst_miss");
      step(mk(1, 0, 32'h000, 0, 1, I0, 0, 0, 1, I0, 32'h000, 0, 0), "post_rst_done");
      step(mk(1, 0, 32'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_xfer");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
